// File: rtl/pid_error_stage.sv
// Error-conditioning stage: registers the proportional term together with a
// saturating running integral and a saturating first difference.
module pid_error_stage #(
  parameter int WIDTH   = 16,
  parameter int INT_LIM = 2**(WIDTH-1)-1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clr,
  input  logic                    i_err_valid,
  input  logic signed [WIDTH-1:0] i_err,
  output logic                    o_err_ready,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic signed [WIDTH-1:0] o_prop,
  output logic signed [WIDTH-1:0] o_integ,
  output logic signed [WIDTH-1:0] o_deriv,
  output logic                    o_sat_int,
  output logic                    o_sat_der
);

  localparam logic signed [WIDTH:0]   LIM_POS = (WIDTH+1)'(INT_LIM);
  localparam logic signed [WIDTH:0]   LIM_NEG = -LIM_POS;
  localparam logic signed [WIDTH-1:0] D_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] D_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic signed [WIDTH-1:0] clamp_int(input logic signed [WIDTH:0] v);
    if (v > LIM_POS) begin
      clamp_int = LIM_POS[WIDTH-1:0];
    end else if (v < LIM_NEG) begin
      clamp_int = LIM_NEG[WIDTH-1:0];
    end else begin
      clamp_int = v[WIDTH-1:0];
    end
  endfunction

  function automatic logic int_clamped(input logic signed [WIDTH:0] v);
    int_clamped = (v > LIM_POS) || (v < LIM_NEG);
  endfunction

  // A WIDTH+1 difference overflows WIDTH exactly when its top two bits differ.
  function automatic logic signed [WIDTH-1:0] clamp_der(input logic signed [WIDTH:0] v);
    case ({v[WIDTH], v[WIDTH-1]})
      2'b01:   clamp_der = D_MAX;
      2'b10:   clamp_der = D_MIN;
      default: clamp_der = v[WIDTH-1:0];
    endcase
  endfunction

  function automatic logic der_clamped(input logic signed [WIDTH:0] v);
    der_clamped = v[WIDTH] ^ v[WIDTH-1];
  endfunction

  logic signed [WIDTH-1:0] r_acc_int;
  logic signed [WIDTH-1:0] r_e_prev;
  logic                    r_first;
  logic                    r_out_valid;
  logic signed [WIDTH-1:0] r_prop;
  logic signed [WIDTH-1:0] r_integ;
  logic signed [WIDTH-1:0] r_deriv;
  logic                    r_sat_int;
  logic                    r_sat_der;

  logic                    w_acc;
  logic signed [WIDTH-1:0] w_int_eff;
  logic                    w_first_eff;
  logic signed [WIDTH:0]   w_sum;
  logic signed [WIDTH:0]   w_diff;
  logic signed [WIDTH-1:0] w_integ_new;
  logic                    w_sat_int_new;
  logic signed [WIDTH-1:0] w_deriv_new;
  logic                    w_sat_der_new;

  assign o_err_ready = ~r_out_valid | i_out_ready;
  assign w_acc       = i_err_valid & o_err_ready;
  assign o_out_valid = r_out_valid;
  assign o_prop      = r_prop;
  assign o_integ     = r_integ;
  assign o_deriv     = r_deriv;
  assign o_sat_int   = r_sat_int;
  assign o_sat_der   = r_sat_der;

  // New result for the incoming sample; a same-cycle clear acts as empty history.
  always_comb begin
    w_int_eff     = r_acc_int;
    w_first_eff   = r_first;
    w_deriv_new   = {WIDTH{1'b0}};
    w_sat_der_new = 1'b0;
    if (i_clr) begin
      w_int_eff   = {WIDTH{1'b0}};
      w_first_eff = 1'b1;
    end else begin
      w_int_eff   = r_acc_int;
      w_first_eff = r_first;
    end
    w_sum         = {w_int_eff[WIDTH-1], w_int_eff} + {i_err[WIDTH-1], i_err};
    w_diff        = {i_err[WIDTH-1], i_err} - {r_e_prev[WIDTH-1], r_e_prev};
    w_integ_new   = clamp_int(w_sum);
    w_sat_int_new = int_clamped(w_sum);
    if (w_first_eff) begin
      w_deriv_new   = {WIDTH{1'b0}};
      w_sat_der_new = 1'b0;
    end else begin
      w_deriv_new   = clamp_der(w_diff);
      w_sat_der_new = der_clamped(w_diff);
    end
  end

  // Single-entry output register with valid/ready handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_prop      <= {WIDTH{1'b0}};
      r_integ     <= {WIDTH{1'b0}};
      r_deriv     <= {WIDTH{1'b0}};
      r_sat_int   <= 1'b0;
      r_sat_der   <= 1'b0;
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_prop      <= i_err;
      r_integ     <= w_integ_new;
      r_deriv     <= w_deriv_new;
      r_sat_int   <= w_sat_int_new;
      r_sat_der   <= w_sat_der_new;
    end else if (r_out_valid && i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Integrator and derivative history; clear only affects this state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc_int <= {WIDTH{1'b0}};
      r_e_prev  <= {WIDTH{1'b0}};
      r_first   <= 1'b1;
    end else if (w_acc) begin
      r_acc_int <= w_integ_new;
      r_e_prev  <= i_err;
      r_first   <= 1'b0;
    end else if (i_clr) begin
      r_acc_int <= {WIDTH{1'b0}};
      r_e_prev  <= {WIDTH{1'b0}};
      r_first   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pid_error_stage.sv
// Bench for pid_error_stage: two instances (full-scale and INT_LIM=1000 clamp)
// driven in lockstep and compared against an integer reference model.
module tb_pid_error_stage;

  logic               clk = 1'b0;
  logic               rst_n, clr, err_valid, out_ready;
  logic signed [15:0] err;

  logic               rdy_a, val_a, sint_a, sder_a;
  logic signed [15:0] prop_a, integ_a, deriv_a;
  logic               rdy_b, val_b, sint_b, sder_b;
  logic signed [15:0] prop_b, integ_b, deriv_b;

  pid_error_stage #(.WIDTH(16), .INT_LIM(32767)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_err_valid(err_valid), .i_err(err),
    .o_err_ready(rdy_a), .o_out_valid(val_a), .i_out_ready(out_ready),
    .o_prop(prop_a), .o_integ(integ_a), .o_deriv(deriv_a),
    .o_sat_int(sint_a), .o_sat_der(sder_a));

  pid_error_stage #(.WIDTH(16), .INT_LIM(1000)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_err_valid(err_valid), .i_err(err),
    .o_err_ready(rdy_b), .o_out_valid(val_b), .i_out_ready(out_ready),
    .o_prop(prop_b), .o_integ(integ_b), .o_deriv(deriv_b),
    .o_sat_int(sint_b), .o_sat_der(sder_b));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state (index 0: INT_LIM 32767, index 1: INT_LIM 1000)
  int exp_valid, exp_prop, exp_deriv, exp_sder;
  int exp_integ[2];
  int exp_sint[2];
  int m_int[2];
  int m_prev;
  int m_first;

  function automatic int lim(input int k);
    return (k == 0) ? 32767 : 1000;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_valid = 0; exp_prop = 0; exp_deriv = 0; exp_sder = 0;
    for (int k = 0; k < 2; k++) begin
      exp_integ[k] = 0; exp_sint[k] = 0; m_int[k] = 0;
    end
    m_prev = 0; m_first = 1;
  endtask

  task automatic model_step(input bit v, input int e, input bit rdy, input bit c);
    int s, d;
    if (v && (exp_valid == 0 || rdy)) begin
      for (int k = 0; k < 2; k++) begin
        s = (c ? 0 : m_int[k]) + e;
        if (s > lim(k)) begin
          exp_integ[k] = lim(k); exp_sint[k] = 1;
        end else if (s < -lim(k)) begin
          exp_integ[k] = -lim(k); exp_sint[k] = 1;
        end else begin
          exp_integ[k] = s; exp_sint[k] = 0;
        end
        m_int[k] = exp_integ[k];
      end
      if (c || m_first == 1) begin
        exp_deriv = 0; exp_sder = 0;
      end else begin
        d = e - m_prev;
        if (d > 32767) begin
          exp_deriv = 32767; exp_sder = 1;
        end else if (d < -32768) begin
          exp_deriv = -32768; exp_sder = 1;
        end else begin
          exp_deriv = d; exp_sder = 0;
        end
      end
      exp_prop = e; m_prev = e; m_first = 0; exp_valid = 1;
    end else begin
      if (exp_valid == 1 && rdy) exp_valid = 0;
      if (c) begin
        m_int[0] = 0; m_int[1] = 0; m_prev = 0; m_first = 1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("out_valid_a", 32'(val_a), exp_valid);
    chk("out_valid_b", 32'(val_b), exp_valid);
    chk("prop_a", 32'(prop_a), exp_prop);
    chk("prop_b", 32'(prop_b), exp_prop);
    chk("integ_a", 32'(integ_a), exp_integ[0]);
    chk("integ_b", 32'(integ_b), exp_integ[1]);
    chk("deriv_a", 32'(deriv_a), exp_deriv);
    chk("deriv_b", 32'(deriv_b), exp_deriv);
    chk("sat_int_a", 32'(sint_a), exp_sint[0]);
    chk("sat_int_b", 32'(sint_b), exp_sint[1]);
    chk("sat_der_a", 32'(sder_a), exp_sder);
    chk("sat_der_b", 32'(sder_b), exp_sder);
  endtask

  // one clock: drive at edge+1, check ready before the edge, check outputs after it
  task automatic cycle(input bit v, input int e, input bit rdy, input bit c);
    int exp_rdy;
    err_valid = v; err = e[15:0]; out_ready = rdy; clr = c;
    #1;
    exp_rdy = (exp_valid == 0 || rdy) ? 1 : 0;
    chk("err_ready_a", 32'(rdy_a), exp_rdy);
    chk("err_ready_b", 32'(rdy_b), exp_rdy);
    @(posedge clk);
    model_step(v, e, rdy, c);
    #1;
    check_outputs();
  endtask

  initial begin
    int e;
    rst_n = 1'b0; clr = 1'b0; err_valid = 1'b0; out_ready = 1'b0; err = 16'sd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // basic sequence
    cycle(1'b1, 100, 1'b1, 1'b0);
    cycle(1'b1, 50, 1'b1, 1'b0);
    cycle(1'b1, -30, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b1);
    // positive integral saturation
    cycle(1'b1, 30000, 1'b1, 1'b0);
    cycle(1'b1, 30000, 1'b1, 1'b0);
    cycle(1'b1, -100, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b1);
    // derivative clamp both directions
    cycle(1'b1, 32767, 1'b1, 1'b0);
    cycle(1'b1, -32768, 1'b1, 1'b0);
    cycle(1'b1, 32767, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b1);
    // small integral limit exercised on dut_b
    cycle(1'b1, 600, 1'b1, 1'b0);
    cycle(1'b1, 600, 1'b1, 1'b0);
    cycle(1'b1, -3000, 1'b1, 1'b0);
    // backpressure: 7 held off for five cycles, then taken exactly once
    cycle(1'b1, 3, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 7, 1'b0, 1'b0);
    cycle(1'b1, 7, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    // clear with accept, then clear alone under backpressure
    cycle(1'b0, 0, 1'b1, 1'b1);
    cycle(1'b1, 500, 1'b1, 1'b0);
    cycle(1'b1, 20, 1'b1, 1'b1);
    cycle(1'b1, 25, 1'b1, 1'b0);
    cycle(1'b1, 9, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b1, 40, 1'b1, 1'b0);

    // randomized traffic biased toward the extremes
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0:       e = 32767;
        1:       e = -32768;
        2:       e = int'($urandom_range(0, 2000)) - 1000;
        default: e = int'($urandom_range(0, 65535)) - 32768;
      endcase
      cycle($urandom_range(0, 3) != 0, e, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end

    // reset in the middle of a transfer discards the result immediately
    cycle(1'b1, 1234, 1'b1, 1'b0);
    err_valid = 1'b1; err = 16'sd77;
    rst_n = 1'b0;
    #2;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    cycle(1'b1, 5, 1'b1, 1'b0);
    cycle(1'b1, -5, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pid_error_stage.md
# pid_error_stage

Registered error-conditioning stage directly downstream of the 16-bit error adder in the PID datapath. It accepts one signed error sample per handshake and produces, one cycle later, the proportional term (the error itself), a saturating running integral and a saturating first difference (derivative). It holds these in a single-entry output register with valid/ready flow control, feeding the gain/multiply stage.

## Interface
- WIDTH, 16, data width of error and all outputs (two's complement).
- INT_LIM, 2**(WIDTH-1)-1, positive integral clamp magnitude; integral is held in [-INT_LIM, +INT_LIM]; must be ≤ 2**(WIDTH-1)-1.

- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear of integrator/history (does not touch output register).
- err_valid  in  1  error sample valid.
- err  in  WIDTH  signed error sample (adder result).
- err_ready  out  1  stage can accept a sample.
- out_valid  out  1  output register holds an unconsumed result.
- out_ready  in  1  downstream accepts result.
- prop  out  WIDTH  registered error of the result.
- integ  out  WIDTH  saturated running integral after this sample.
- deriv  out  WIDTH  saturated err − previous err.
- sat_int  out  1  integral clamped on this sample.
- sat_der  out  1  derivative clamped on this sample.

## Operation
- Accept: acc = err_valid & err_ready; err_ready = ~out_valid | out_ready (combinational, single-entry pipeline register, full throughput).
- Internal state: acc_int (WIDTH, signed), e_prev (WIDTH), first (1 = no history).
- On acc: s = acc_int_eff + err computed at WIDTH+1 bits; integ_new = clamp(s, −INT_LIM, +INT_LIM); sat_int = (s was clamped).
- d = err − e_prev at WIDTH+1 bits; deriv_new = clamp(d, −2**(WIDTH-1), 2**(WIDTH-1)−1); sat_der = (d was clamped). If first_eff = 1, deriv_new = 0, sat_der = 0.
- On acc: prop←err, integ←integ_new, deriv←deriv_new, flags updated, acc_int←integ_new, e_prev←err, first←0, out_valid←1.
- No acc and out_valid & out_ready: out_valid←0; data outputs hold last values.
- clr alone: acc_int←0, e_prev←0, first←1; out_valid and output registers unchanged.
- clr with acc same cycle: sample is processed with acc_int_eff = 0 and first_eff = 1 (integ = clamp(err), deriv = 0); afterwards first←0, e_prev←err.
- Without clr: acc_int_eff = acc_int, first_eff = first.
- No wrap-around anywhere: all overflow is clamped.

## Timing
- Reset (rst_n = 0, immediate): out_valid=0, prop=0, integ=0, deriv=0, sat_int=0, sat_der=0, acc_int=0, e_prev=0, first=1; err_ready=1 once reset released.
- Latency: sample accepted at edge N is visible on outputs with out_valid=1 after edge N.
- Throughput: one sample per cycle while out_ready=1.
- Backpressure: out_valid=1 & out_ready=0 → err_ready=0; outputs and flags stable until consumed.
- Simultaneous consume + accept: out_valid stays 1, outputs replaced with new result in the same edge.
- Reset asserted mid-transfer: result in flight is discarded; all state to reset values asynchronously.

## Test plan
- Reset then samples 100, 50, −30 with out_ready=1 → integ 100, 150, 120; deriv 0, −50, −80; prop mirrors err; out_valid high 3 consecutive cycles.
- Positive saturation (WIDTH=16, INT_LIM=32767): samples 30000, 30000 → integ 30000 then 32767, sat_int 0 then 1; then −100 → integ 32667, sat_int 0.
- Derivative clamp: samples 32767 then −32768 → deriv 0 then −32768 with sat_der=1 (true −65535); then 32767 → deriv 32767, sat_der=1.
- INT_LIM=1000: samples 600, 600, −3000 → integ 600, 1000 (sat_int=1), −1000 (sat_int=1).
- Backpressure: out_ready=0 after first result, err_valid held with 7 → err_ready=0, outputs frozen 5 cycles; raise out_ready → sample 7 accepted that edge, new result next cycle, no sample lost or duplicated.
- clr with accept: integ=500 history, assert clr with err=20 → integ 20, deriv 0; next err 25 → integ 45, deriv 5; clr alone while out_valid=1 & out_ready=0 leaves outputs unchanged.
